// File: rtl/mem_copy_pkg.sv
// Shared constants and FSM state encoding for the memory block copier.
`default_nettype none

package mem_copy_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_e;

    function automatic logic is_word_aligned(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_addr_gen.sv
// Loadable word-address pointer: load takes priority, inc steps by one word and wraps mod 2^32.
`default_nettype none

module mem_addr_gen
    import mem_copy_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_addr_i;
        end else if (inc_i) begin
            addr_d = addr_q + ADDR_W'(WORD_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

`default_nettype wire

// File: rtl/mem_block_copier.sv
// Word-memory block copier (start/done handshake, read-then-write per word).
// Optional running checksum output enabled by defining MEM_COPY_CHECKSUM_EN.
`default_nettype none

module mem_block_copier
    import mem_copy_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  words_done
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int WAIT_W = 4;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   wd_q, wd_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               ptr_load;
    logic               ptr_inc;
    logic [ADDR_W-1:0]  src_ptr;
    logic [ADDR_W-1:0]  dst_ptr;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0]  csum_q, csum_d;
`endif

    mem_addr_gen u_src_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (ptr_load),
        .load_addr_i (src_addr),
        .inc_i       (ptr_inc),
        .addr_o      (src_ptr)
    );

    mem_addr_gen u_dst_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (ptr_load),
        .load_addr_i (dst_addr),
        .inc_i       (ptr_inc),
        .addr_o      (dst_ptr)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        wait_d    = wait_q;
        data_d    = data_q;
        err_d     = err_q;
        busy_d    = busy_q;
        ptr_load  = 1'b0;
        ptr_inc   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d    = word_count;
                    wd_d     = '0;
                    wait_d   = '0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    ptr_load = 1'b1;
`ifdef MEM_COPY_CHECKSUM_EN
                    csum_d   = '0;
`endif
                    if (!is_word_aligned(src_addr) || !is_word_aligned(dst_addr)) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else if (word_count == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                mem_read = 1'b1;
                mem_addr = src_ptr;
                if (wait_q == WAIT_W'(WAIT_CYCLES)) begin
                    data_d  = mem_rdata;
                    wait_d  = '0;
                    state_d = WR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WR: begin
                mem_write = 1'b1;
                mem_addr  = dst_ptr;
                mem_wdata = data_q;
                ptr_inc   = 1'b1;
                wd_d      = wd_q + CNT_W'(1);
`ifdef MEM_COPY_CHECKSUM_EN
                csum_d    = {csum_q[DATA_W-2:0], csum_q[DATA_W-1]} ^ data_q;
`endif
                if (wd_d == cnt_q) begin
                    state_d = FIN;
                    busy_d  = 1'b0;
                end else begin
                    state_d = RD;
                end
            end
            FIN: begin
                // Rejected/empty requests reach FIN with busy still set; it drops here.
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wd_q    <= '0;
            wait_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            wait_q  <= wait_d;
            data_q  <= data_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
`ifdef MEM_COPY_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign err        = err_q;
    assign words_done = wd_q;
`ifdef MEM_COPY_CHECKSUM_EN
    assign checksum   = csum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_block_copier.sv
// Directed bench for mem_block_copier: two copies (WAIT_CYCLES 0 and 3) on mirrored 32-word memories.
`default_nettype none

module tb_mem_block_copier;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start, start3;
    logic [31:0] src, dst;
    logic [15:0] cnt;

    logic        rd, wr, busy, done, err;
    logic [31:0] addr, wdata, rdata;
    logic [15:0] wd;
    logic        rd3, wr3, busy3, done3, err3;
    logic [31:0] addr3, wdata3, rdata3;
    logic [15:0] wd3;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0] csum, csum3;
`endif

    logic [31:0] mem  [0:31];
    logic [31:0] mem3 [0:31];
    logic        do_preload;

    int total = 0;
    int bad   = 0;

    mem_block_copier #(.CNT_W(16), .WAIT_CYCLES(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .src_addr(src), .dst_addr(dst), .word_count(cnt), .mem_rdata(rdata),
        .mem_read(rd), .mem_write(wr), .mem_addr(addr), .mem_wdata(wdata),
        .busy(busy), .done(done), .err(err), .words_done(wd)
`ifdef MEM_COPY_CHECKSUM_EN
        , .checksum(csum)
`endif
    );

    mem_block_copier #(.CNT_W(16), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3),
        .src_addr(src), .dst_addr(dst), .word_count(cnt), .mem_rdata(rdata3),
        .mem_read(rd3), .mem_write(wr3), .mem_addr(addr3), .mem_wdata(wdata3),
        .busy(busy3), .done(done3), .err(err3), .words_done(wd3)
`ifdef MEM_COPY_CHECKSUM_EN
        , .checksum(csum3)
`endif
    );

    // Mirror-decoded memories: only address bits [6:2] select a word.
    assign rdata  = rd  ? mem[addr[6:2]]   : 32'h0;
    assign rdata3 = rd3 ? mem3[addr3[6:2]] : 32'h0;

    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 32; i++) begin
                mem[i]  <= 32'hA000_0000 + 32'(i);
                mem3[i] <= 32'hA000_0000 + 32'(i);
            end
        end else begin
            if (wr)  mem[addr[6:2]]   <= wdata;
            if (wr3) mem3[addr3[6:2]] <= wdata3;
        end
    end

    int          wr_count = 0, rd_count = 0, done_cnt = 0, busy_cnt = 0, rd3_count = 0;
    int          excl_viol = 0, long_done = 0, idle_addr_viol = 0;
    logic        done_prev = 1'b0, done3_prev = 1'b0;
    logic [31:0] rd_addrs[$];

    always @(negedge clk) begin
        if (wr)   wr_count++;
        if (rd) begin
            rd_count++;
            rd_addrs.push_back(addr);
        end
        if (rd3)  rd3_count++;
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if ((rd && wr) || (rd3 && wr3)) excl_viol++;
        if ((done && done_prev) || (done3 && done3_prev)) long_done++;
        if ((!rd && !wr && addr != 32'h0) || (!rd3 && !wr3 && addr3 != 32'h0)) idle_addr_viol++;
        done_prev  <= done;
        done3_prev <= done3;
    end

    task automatic preload();
        do_preload = 1'b1;
        @(posedge clk); #1;
        do_preload = 1'b0;
    endtask

    task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [15:0] c);
        src = s; dst = d; cnt = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // n = cycles elapsed since the start cycle; start..done inclusive spans n+1 cycles.
    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (done !== 1'b1) begin
            total++; bad++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({rd, wr, addr, wdata, busy, done, err, wd} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: rd=%b wr=%b addr=%h wdata=%h busy=%b done=%b err=%b wd=%0d, required all 0",
                     rd, wr, addr, wdata, busy, done, err, wd);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_copy();
        int n;
        int w0;
        preload();
        w0 = wr_count;
        go(32'h0, 32'h40, 16'd4);
        wait_done(n);
        total++;
        if (n + 1 !== 10) begin bad++; $display("FAIL basic_latency: got %0d cycles, required 10", n + 1); end
        total++;
        if ({busy, err, wd} !== {1'b0, 1'b0, 16'd4}) begin
            bad++; $display("FAIL basic_status: busy=%b err=%b wd=%0d, required 0 0 4", busy, err, wd);
        end
        total++;
        if (wr_count - w0 !== 4) begin bad++; $display("FAIL basic_writes: got %0d, required 4", wr_count - w0); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[16+i] !== 32'hA000_0000 + 32'(i)) begin
                bad++; $display("FAIL basic_data[%0d]: got %h, required %h", 16 + i, mem[16+i], 32'hA000_0000 + 32'(i));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_unaligned();
        int n;
        int w0, r0, d0, b0;
        w0 = wr_count; r0 = rd_count; d0 = done_cnt; b0 = busy_cnt;
        go(32'h2, 32'h40, 16'd3);
        wait_done(n);
        total++;
        if (n + 1 !== 2) begin bad++; $display("FAIL unaligned_latency: got %0d, required 2", n + 1); end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL unaligned_err: got %b, required 1", err); end
        total++;
        if ((wr_count - w0) + (rd_count - r0) !== 0) begin
            bad++; $display("FAIL unaligned_strobes: got %0d strobe cycles, required 0", (wr_count - w0) + (rd_count - r0));
        end
        total++;
        if (done_cnt - d0 !== 1) begin bad++; $display("FAIL unaligned_done_count: got %0d, required 1", done_cnt - d0); end
        total++;
        if (busy_cnt - b0 !== 1) begin bad++; $display("FAIL unaligned_busy_cycles: got %0d, required 1", busy_cnt - b0); end
    endtask

    task automatic test_zero_count();
        int n;
        logic ok;
        preload();
        go(32'h0, 32'h40, 16'd0);
        wait_done(n);
        total++;
        if ({err, wd} !== 17'd0 || n + 1 !== 2) begin
            bad++; $display("FAIL zero_status: err=%b wd=%0d cycles=%0d, required 0 0 2", err, wd, n + 1);
        end
        ok = 1'b1;
        for (int i = 0; i < 32; i++) if (mem[i] !== 32'hA000_0000 + 32'(i)) ok = 1'b0;
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL zero_mem_unchanged: got %b, required 1", ok); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n;
        int d0, w0;
        preload();
        d0 = done_cnt; w0 = wr_count;
        src = 32'h0; dst = 32'h40; cnt = 16'd8; start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            src = 32'h80; cnt = 16'd2;
        end while (done !== 1'b1 && n < 300);
        start = 1'b0;
        total++;
        if (n + 1 !== 18) begin bad++; $display("FAIL b2b_latency: got %0d, required 18", n + 1); end
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (done_cnt - d0 !== 1) begin bad++; $display("FAIL b2b_done_count: got %0d, required 1", done_cnt - d0); end
        total++;
        if (wd !== 16'd8 || wr_count - w0 !== 8) begin
            bad++; $display("FAIL b2b_words: wd=%0d writes=%0d, required 8 8", wd, wr_count - w0);
        end
        total++;
        if (mem[23] !== 32'hA000_0007 || mem[16] !== 32'hA000_0000) begin
            bad++; $display("FAIL b2b_data: mem16=%h mem23=%h, required a0000000 a0000007", mem[16], mem[23]);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        int w0, d0;
        preload();
        w0 = wr_count; d0 = done_cnt;
        go(32'h0, 32'h40, 16'd6);
        k = 0;
        while (wr_count - w0 < 2 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({rd, wr, addr, wdata, busy, done, err, wd} !== '0) begin
            bad++; $display("FAIL midreset_outputs: rd=%b wr=%b addr=%h busy=%b wd=%0d, required all 0", rd, wr, addr, busy, wd);
        end
        reset_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        total++;
        if (wr_count - w0 !== 2 || done_cnt - d0 !== 0) begin
            bad++; $display("FAIL midreset_activity: writes=%0d dones=%0d, required 2 0", wr_count - w0, done_cnt - d0);
        end
        total++;
        if (mem[17] !== 32'hA000_0001 || mem[18] !== 32'hA000_0012) begin
            bad++; $display("FAIL midreset_mem: mem17=%h mem18=%h, required a0000001 a0000012", mem[17], mem[18]);
        end
    endtask

    task automatic test_wrap();
        int n;
        int q0;
        preload();
        q0 = rd_addrs.size();
        go(32'hFFFF_FFF8, 32'h40, 16'd3);
        wait_done(n);
        total++;
        if (rd_addrs.size() - q0 !== 3) begin
            bad++; $display("FAIL wrap_read_count: got %0d, required 3", rd_addrs.size() - q0);
        end else begin
            total++;
            if ({rd_addrs[q0], rd_addrs[q0+1], rd_addrs[q0+2]} !== {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0}) begin
                bad++; $display("FAIL wrap_addrs: got %h %h %h, required fffffff8 fffffffc 00000000",
                                rd_addrs[q0], rd_addrs[q0+1], rd_addrs[q0+2]);
            end
        end
        total++;
        if ({mem[16], mem[17], mem[18]} !== {32'hA000_001E, 32'hA000_001F, 32'hA000_0000}) begin
            bad++; $display("FAIL wrap_data: got %h %h %h, required a000001e a000001f a0000000", mem[16], mem[17], mem[18]);
        end
`ifdef MEM_COPY_CHECKSUM_EN
        total++;
        if (csum !== 32'h6000_0045) begin bad++; $display("FAIL wrap_checksum: got %h, required 60000045", csum); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_wait3();
        int n;
        int r0;
        preload();
        r0 = rd3_count;
        src = 32'h0; dst = 32'h40; cnt = 16'd2; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        n = 1;
        while (done3 !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n + 1 !== 12) begin bad++; $display("FAIL wait3_latency: got %0d, required 12", n + 1); end
        total++;
        if (rd3_count - r0 !== 8) begin bad++; $display("FAIL wait3_read_cycles: got %0d, required 8", rd3_count - r0); end
        total++;
        if ({mem3[16], mem3[17], wd3} !== {32'hA000_0000, 32'hA000_0001, 16'd2}) begin
            bad++; $display("FAIL wait3_data: got %h %h wd=%0d, required a0000000 a0000001 2", mem3[16], mem3[17], wd3);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_protocol();
        total++;
        if (excl_viol !== 0) begin bad++; $display("FAIL strobe_exclusive: got %0d violations, required 0", excl_viol); end
        total++;
        if (long_done !== 0) begin bad++; $display("FAIL done_single_cycle: got %0d violations, required 0", long_done); end
        total++;
        if (idle_addr_viol !== 0) begin bad++; $display("FAIL idle_addr_zero: got %0d violations, required 0", idle_addr_viol); end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; start3 = 1'b0; do_preload = 1'b0;
        src = '0; dst = '0; cnt = '0;
        test_reset();
        test_basic_copy();
        test_unaligned();
        test_zero_count();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_wait3();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
